// File: rtl/mantissa_normalizer_if.sv
`default_nettype none
// ==========================================================================
// Module   : mantissa_normalizer_if
// Purpose  : upstream/downstream handshake and data bundle for the normalizer
// Revision : 1.0
// ==========================================================================
interface mantissa_normalizer_if #(
  parameter int SIZE_MANTISSA = 28,
  parameter int SIZE_EXPONENT = 8
);
  localparam int SW = $clog2(SIZE_MANTISSA) + 1;

  logic                     i_valid;
  logic                     o_ready;
  logic                     i_overflow;
  logic                     i_sign;
  logic [SIZE_EXPONENT-1:0] i_exponent;
  logic [SIZE_MANTISSA-1:0] i_mantissa;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_sign;
  logic [SIZE_EXPONENT-1:0] o_exponent;
  logic [SIZE_MANTISSA-1:0] o_mantissa;
  logic [SW-1:0]            o_shift_count;
  logic                     o_zero;
  logic                     o_denorm;
  logic                     o_exp_overflow;

  modport slave (
    input  i_valid, i_overflow, i_sign, i_exponent, i_mantissa, i_ready,
    output o_ready, o_valid, o_sign, o_exponent, o_mantissa, o_shift_count,
           o_zero, o_denorm, o_exp_overflow
  );

  modport master (
    output i_valid, i_overflow, i_sign, i_exponent, i_mantissa, i_ready,
    input  o_ready, o_valid, o_sign, o_exponent, o_mantissa, o_shift_count,
           o_zero, o_denorm, o_exp_overflow
  );
endinterface
`default_nettype wire

// File: rtl/mantissa_normalizer.sv
`default_nettype none
// ==========================================================================
// Module   : mantissa_normalizer
// Purpose  : iterative post-add mantissa normalization with exponent adjust
// Revision : 1.0
// ==========================================================================
module mantissa_normalizer #(
  parameter int SIZE_MANTISSA = 28,
  parameter int SIZE_EXPONENT = 8
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  mantissa_normalizer_if.slave bus
);
  localparam int SW = $clog2(SIZE_MANTISSA) + 1;
  localparam logic [SW-1:0]            C_CNT_MAX = SW'(SIZE_MANTISSA - 1);
  localparam logic [SIZE_EXPONENT-1:0] C_EXP_ONE = SIZE_EXPONENT'(1);
  localparam logic [SIZE_EXPONENT-1:0] C_EXP_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     alive_q;
  logic                     ovf_q, ovf_d;
  logic                     sign_q, sign_d;
  logic [SIZE_EXPONENT-1:0] exp_q, exp_d;
  logic [SIZE_MANTISSA-1:0] mant_q, mant_d;
  logic [SW-1:0]            cnt_q, cnt_d;
  logic                     zero_q, zero_d;
  logic                     denorm_q, denorm_d;
  logic                     expovf_q, expovf_d;
  logic [SIZE_EXPONENT-1:0] exp_inc;

  assign exp_inc = exp_q + C_EXP_ONE;

  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    expovf_d = expovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid && alive_q) begin
          ovf_d    = bus.i_overflow;
          sign_d   = bus.i_sign;
          exp_d    = bus.i_exponent;
          mant_d   = bus.i_mantissa;
          cnt_d    = '0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          expovf_d = 1'b0;
          state_d  = S_NORM;
        end
      end
      S_NORM: begin
        if (ovf_q) begin
          // Shift the carry back in while keeping the sticky bit sticky.
          mant_d   = {1'b1, mant_q[SIZE_MANTISSA-1:2], mant_q[1] | mant_q[0]};
          exp_d    = exp_inc;
          expovf_d = (exp_inc == C_EXP_MAX);
          state_d  = S_DONE;
        end else if (mant_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          sign_d  = 1'b0;
          state_d = S_DONE;
        end else if (mant_q[SIZE_MANTISSA-1]) begin
          state_d = S_DONE;
        end else if (exp_q <= C_EXP_ONE) begin
          denorm_d = 1'b1;
          exp_d    = '0;
          state_d  = S_DONE;
        end else begin
          mant_d = {mant_q[SIZE_MANTISSA-2:0], 1'b0};
          exp_d  = exp_q - C_EXP_ONE;
          if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      alive_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      expovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      expovf_q <= expovf_d;
    end
  end

  // alive_q keeps o_ready low while reset is asserted even though the FSM sits in IDLE.
  assign bus.o_ready        = alive_q && (state_q == S_IDLE);
  assign bus.o_valid        = (state_q == S_DONE);
  assign bus.o_sign         = sign_q;
  assign bus.o_exponent     = exp_q;
  assign bus.o_mantissa     = mant_q;
  assign bus.o_shift_count  = cnt_q;
  assign bus.o_zero         = zero_q;
  assign bus.o_denorm       = denorm_q;
  assign bus.o_exp_overflow = expovf_q;
endmodule
`default_nettype wire
